// File: rtl/sum_accumulator_19bit.sv
// Batch accumulator for the 19-bit adder sum stream: N_SAMPLES handshaked words -> one total.
// Define SUM_ACC_SATURATE_EN to clamp the total at 2^ACC_W-1 instead of wrapping.
module sum_accumulator_19bit #(
    parameter int IN_W      = 19,
    parameter int ACC_W     = 26,
    parameter int N_SAMPLES = 100,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             ovf_nx;
    logic [ACC_W:0]   sum;

    // One spare MSB catches the carry out of the accumulator.
    assign sum = {1'b0, acc_out} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc_out  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            acc_out  <= acc_nx;
            count    <= cnt_nx;
            overflow <= ovf_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc_out;
        cnt_nx    = count;
        ovf_nx    = overflow;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    cnt_nx = count + 1'b1;
                    if (sum[ACC_W]) begin
                        ovf_nx = 1'b1;
                    end
`ifdef SUM_ACC_SATURATE_EN
                    if (sum[ACC_W] || overflow) begin
                        acc_nx = '1;
                    end else begin
                        acc_nx = sum[ACC_W-1:0];
                    end
`else
                    acc_nx = sum[ACC_W-1:0];
`endif
                    if (count == LAST) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
